// File: rtl/echo_delay.sv
// Single-tap echo with feedback over a block-RAM delay line.
// Each accepted sample takes READ -> WAIT -> CALC before the next one can be accepted.
module echo_delay #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         audio_ready,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic                         en,
    input  logic        [ADDR_WIDTH-1:0] delay_len,
    input  logic        [3:0]            fb_shift,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         y_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         wrap
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CALC  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] MIN_LEN   = ADDR_WIDTH'(1);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Sum at one extra bit, then clamp if the two top bits disagree.
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] rd_data_q;

    logic [2:0]                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]        len_q, len_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d;
    logic                         en_q, en_d;
    logic [3:0]                   fb_q, fb_d;
    logic signed [DATA_WIDTH-1:0] y_q, y_d;
    logic                         y_valid_q, y_valid_d;
    logic                         overrun_q, overrun_d;
    logic                         wrap_q, wrap_d;

    logic                         ram_we;
    logic [ADDR_WIDTH-1:0]        ram_waddr;
    logic signed [DATA_WIDTH-1:0] ram_wdata;
    logic                         ram_re;
    logic [ADDR_WIDTH-1:0]        ram_raddr;
    logic signed [DATA_WIDTH-1:0] d_shift;

    assign d_shift = rd_data_q >>> fb_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        x_d       = x_q;
        en_d      = en_q;
        fb_d      = fb_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        overrun_d = overrun_q;
        wrap_d    = wrap_q;
        ram_we    = 1'b0;
        ram_waddr = wr_ptr_q;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = wr_ptr_q - len_q;

        if (audio_ready && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + MIN_LEN;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (audio_ready) begin
                    x_d     = x;
                    en_d    = en;
                    fb_d    = fb_shift;
                    len_d   = (delay_len == '0) ? MIN_LEN : delay_len;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                ram_re  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                // Bypass still writes the dry sample so re-enabling echo has history.
                ram_we = 1'b1;
                if (en_q) begin
                    y_d       = sat_add(x_q, rd_data_q);
                    ram_wdata = (fb_q == 4'd0) ? x_q : sat_add(x_q, d_shift);
                end else begin
                    y_d       = x_q;
                    ram_wdata = x_q;
                end
                y_valid_d = 1'b1;
                wr_ptr_d  = wr_ptr_q + MIN_LEN;
                if (wr_ptr_q == LAST_ADDR) begin
                    wrap_d = ~wrap_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            len_q     <= MIN_LEN;
            x_q       <= '0;
            en_q      <= 1'b0;
            fb_q      <= 4'd0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
            x_q       <= x_d;
            en_q      <= en_d;
            fb_q      <= fb_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
            wrap_q    <= wrap_d;
        end
    end

    // RAM has no reset so it maps onto block RAM; CLEAR zeroes it instead.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) begin
            rd_data_q <= mem[ram_raddr];
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != S_IDLE);
    assign overrun = overrun_q;
    assign wrap    = wrap_q;

endmodule
